// File: rtl/mem_access.sv
// mem_access: MEM-stage load/store unit driving a req/gnt/rvalid data-memory port.
// Optional misalignment trap enabled by defining MEM_ACCESS_MISALIGN_TRAP_EN.
`default_nettype none

module mem_access #(
    parameter int BUS_TIMEOUT = 64,
    parameter int CNT_W       = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memReadM,
    input  logic        memWriteM,
    input  logic [1:0]  memSizeM,
    input  logic        memUnsignedM,
    input  logic [31:0] aluOutM,
    input  logic [31:0] writeDataM,
    output logic        stallM,
    output logic [31:0] readDataM,
    output logic        busErrM,
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    output logic        misalignM,
`endif
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       lat_size;
    logic             lat_uns;
    logic [1:0]       lat_off;

    logic             access;
    logic             is_word;
    logic             is_half;
    logic             trap;
    logic             expire;
    logic [1:0]       eff_off;
    logic [31:0]      st_wdata;
    logic [3:0]       st_wstrb;
    logic [31:0]      shifted;
    logic [31:0]      ld_data;

    assign access  = memReadM | memWriteM;
    assign is_word = memSizeM[1];
    assign is_half = (memSizeM == 2'b01);
    assign expire  = (cnt >= CNT_W'(BUS_TIMEOUT - 1));

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    assign trap = (is_half & aluOutM[0]) | (is_word & (|aluOutM[1:0]));
`else
    assign trap = 1'b0;
`endif

    // Misaligned halves/words are force-aligned by dropping the low offset bits.
    always_comb begin
        if (is_word) begin
            eff_off  = 2'b00;
            st_wdata = writeDataM;
            st_wstrb = 4'b1111;
        end else if (is_half) begin
            eff_off  = {aluOutM[1], 1'b0};
            st_wdata = {2{writeDataM[15:0]}};
            st_wstrb = aluOutM[1] ? 4'b1100 : 4'b0011;
        end else begin
            eff_off  = aluOutM[1:0];
            st_wdata = {4{writeDataM[7:0]}};
            st_wstrb = 4'b0001 << aluOutM[1:0];
        end
    end

    always_comb begin
        shifted = dmem_rdata >> {lat_off, 3'b000};
        case (lat_size)
            2'b00:   ld_data = {{24{~lat_uns & shifted[7]}}, shifted[7:0]};
            2'b01:   ld_data = {{16{~lat_uns & shifted[15]}}, shifted[15:0]};
            default: ld_data = dmem_rdata;
        endcase
    end

    always_comb begin
        case (state)
            IDLE:    stallM = access & rst;
            REQ:     stallM = 1'b1;
            RESP:    stallM = 1'b1;
            default: stallM = 1'b0;
        endcase
    end

    assign dmem_req = (state == REQ);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            lat_size   <= 2'b00;
            lat_uns    <= 1'b0;
            lat_off    <= 2'b00;
            readDataM  <= 32'd0;
            busErrM    <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'd0;
            dmem_wdata <= 32'd0;
            dmem_wstrb <= 4'b0000;
        end else begin
            busErrM <= 1'b0;
            case (state)
                IDLE: begin
                    if (access) begin
                        if (trap) begin
                            state <= DONE;
                        end else begin
                            state      <= REQ;
                            cnt        <= '0;
                            lat_size   <= memSizeM;
                            lat_uns    <= memUnsignedM;
                            lat_off    <= eff_off;
                            dmem_we    <= memWriteM;
                            dmem_addr  <= {aluOutM[31:2], 2'b00};
                            dmem_wdata <= st_wdata;
                            dmem_wstrb <= memWriteM ? st_wstrb : 4'b0000;
                        end
                    end
                end
                REQ: begin
                    // A grant arriving on the last counted cycle still wins over the timeout.
                    if (dmem_gnt) begin
                        state <= dmem_we ? DONE : RESP;
                        cnt   <= cnt + CNT_W'(1);
                    end else if (expire) begin
                        state   <= DONE;
                        busErrM <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (dmem_rvalid) begin
                        state     <= DONE;
                        readDataM <= ld_data;
                    end else if (expire) begin
                        state   <= DONE;
                        busErrM <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misalignM <= 1'b0;
        end else begin
            misalignM <= (state == IDLE) & access & trap;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_access.sv
// tb_mem_access: randomized transaction-level check of mem_access against a behavioural model.
`default_nettype none

module tb_mem_access;

    localparam int BT    = 64;
    localparam int NEVER = 100000;

    logic        clk = 1'b0;
    logic        rst;
    logic        memReadM, memWriteM, memUnsignedM;
    logic [1:0]  memSizeM;
    logic [31:0] aluOutM, writeDataM;
    logic        stallM, busErrM;
    logic [31:0] readDataM;
    logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wstrb;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    logic        misalignM;
`endif

    mem_access #(.BUS_TIMEOUT(BT), .CNT_W(7)) dut (
        .clk(clk), .rst(rst),
        .memReadM(memReadM), .memWriteM(memWriteM), .memSizeM(memSizeM),
        .memUnsignedM(memUnsignedM), .aluOutM(aluOutM), .writeDataM(writeDataM),
        .stallM(stallM), .readDataM(readDataM), .busErrM(busErrM),
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        .misalignM(misalignM),
`endif
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    bit          chk_on = 0, chk_bus = 0, chk_wr = 0;
    logic        exp_stall = 0, exp_req = 0, exp_err = 0, exp_we = 0;
    logic [31:0] exp_addr = 0, exp_wdata = 0, model_rd = 0;
    logic [3:0]  exp_wstrb = 0;
    int          stall_cnt = 0, req_cnt = 0, err_cnt = 0;
    logic [31:0] cap_addr = 0, cap_wdata = 0;
    logic [3:0]  cap_wstrb = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
        end
    endtask

    // Byte offset actually used: halves and words ignore their own misaligned bits.
    function automatic int eff_off(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'b00) return int'(a[1:0]);
        if (sz == 2'b01) return a[1] ? 2 : 0;
        return 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic uns,
                                             input logic [31:0] a, input logic [31:0] rd);
        logic [31:0]        v;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] r;
        v = rd >> (8 * eff_off(sz, a));
        if (sz == 2'b00) begin
            b = v[7:0];
            r = b;
            return uns ? {24'd0, v[7:0]} : r;
        end
        if (sz == 2'b01) begin
            h = v[15:0];
            r = h;
            return uns ? {16'd0, v[15:0]} : r;
        end
        return rd;
    endfunction

    task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                             output logic [31:0] wdata, output logic [3:0] wstrb);
        if (sz == 2'b00) begin
            wdata = {24'd0, wd[7:0]} * 32'h0101_0101;
            wstrb = 4'(1 << eff_off(sz, a));
        end else if (sz == 2'b01) begin
            wdata = {16'd0, wd[15:0]} * 32'h0001_0001;
            wstrb = 4'(3 << eff_off(sz, a));
        end else begin
            wdata = wd;
            wstrb = 4'hF;
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("stallM", 32'(stallM), 32'(exp_stall));
            chk("dmem_req", 32'(dmem_req), 32'(exp_req));
            chk("busErrM", 32'(busErrM), 32'(exp_err));
            chk("readDataM", readDataM, model_rd);
            if (chk_bus) begin
                chk("dmem_addr", dmem_addr, exp_addr);
                chk("dmem_we", 32'(dmem_we), 32'(exp_we));
                if (chk_wr) begin
                    chk("dmem_wdata", dmem_wdata, exp_wdata);
                    chk("dmem_wstrb", 32'(dmem_wstrb), 32'(exp_wstrb));
                end
            end
            if (stallM)   stall_cnt++;
            if (dmem_req) begin
                req_cnt++;
                cap_addr  = dmem_addr;
                cap_wdata = dmem_wdata;
                cap_wstrb = dmem_wstrb;
            end
            if (busErrM)  err_cnt++;
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // gd: REQ cycles before grant; rvd: RESP cycles before rvalid (>= BT means never).
    task automatic access(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int gd, input int rvd, input logic [31:0] rdata);
        int t, r;
        bit to, got;
        logic [31:0] ew;
        logic [3:0]  es;
        ref_store(sz, a, wd, ew, es);
        stall_cnt = 0; req_cnt = 0; err_cnt = 0;
        memReadM = rd; memWriteM = wr; memSizeM = sz; memUnsignedM = uns;
        aluOutM = a; writeDataM = wd; dmem_gnt = 0; dmem_rvalid = 0;
        exp_stall = 1; exp_req = 0; exp_err = 0; chk_bus = 0;
        cycle();
        exp_we = wr; exp_addr = a & 32'hFFFF_FFFC; exp_wdata = ew; exp_wstrb = es;
        chk_wr = wr; chk_bus = 1;
        t = 0; to = 0; got = 0;
        while (!got && !to) begin
            t++;
            dmem_gnt    = (t == gd + 1);
            dmem_rvalid = 1'($urandom_range(0, 1));
            dmem_rdata  = $urandom;
            exp_req = 1; exp_stall = 1;
            got = dmem_gnt;
            if (!got && t >= BT) to = 1;
            cycle();
        end
        chk_bus = 0;
        if (!wr && !to) begin
            r = 0; got = 0;
            while (!got && !to) begin
                t++;
                got = (r == rvd);
                dmem_gnt    = 0;
                dmem_rvalid = got;
                dmem_rdata  = got ? rdata : $urandom;
                exp_req = 0; exp_stall = 1;
                if (!got && t >= BT) to = 1;
                r++;
                cycle();
            end
        end
        dmem_gnt = 0; dmem_rvalid = 1'($urandom_range(0, 1)); dmem_rdata = $urandom;
        exp_req = 0; exp_stall = 0; exp_err = to;
        if (!wr && !to) model_rd = ref_load(sz, uns, a, rdata);
        cycle();
        memReadM = 0; memWriteM = 0; dmem_rvalid = 0;
        exp_err = 0; exp_stall = 0; exp_req = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            exp_stall = 0; exp_req = 0; exp_err = 0;
            cycle();
        end
    endtask

    initial begin
        rst = 0; memReadM = 0; memWriteM = 0; memSizeM = 0; memUnsignedM = 0;
        aluOutM = 0; writeDataM = 0; dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
        cycle();
        chk_on = 1; chk_bus = 1; chk_wr = 1;
        cycle();
        rst = 1; chk_bus = 0;
        idle(2);

        access(1, 0, 2'b10, 0, 32'h100, 0, 0, 0, 32'hDEADBEEF);
        chk("lw_stall_cycles", stall_cnt, 3);
        chk("lw_req_cycles", req_cnt, 1);
        chk("lw_data", readDataM, 32'hDEADBEEF);

        access(1, 0, 2'b00, 0, 32'h103, 0, 0, 0, 32'h80AABBCC);
        chk("lb_data", readDataM, 32'hFFFFFF80);
        access(1, 0, 2'b00, 1, 32'h103, 0, 1, 0, 32'h80AABBCC);
        chk("lbu_data", readDataM, 32'h00000080);

        access(0, 1, 2'b01, 0, 32'h202, 32'h1234ABCD, 0, 0, 0);
        chk("sh_addr", cap_addr, 32'h200);
        chk("sh_wstrb", 32'(cap_wstrb), 32'hC);
        chk("sh_wdata", cap_wdata, 32'hABCDABCD);
        chk("sh_keeps_rd", readDataM, 32'h00000080);

        access(1, 0, 2'b10, 0, 32'h40, 0, 5, 3, 32'h13572468);
        chk("slow_req_cycles", req_cnt, 6);
        chk("slow_stall_cycles", stall_cnt, 11);
        chk("slow_data", readDataM, 32'h13572468);

        access(1, 0, 2'b10, 0, 32'h80, 0, NEVER, 0, 32'h0);
        chk("to_err_pulses", err_cnt, 1);
        chk("to_req_cycles", req_cnt, BT);
        chk("to_keeps_rd", readDataM, 32'h13572468);
        idle(1);

        access(1, 0, 2'b01, 0, 32'h84, 0, 2, NEVER, 32'h0);
        chk("resp_to_err_pulses", err_cnt, 1);
        chk("resp_to_stall_cycles", stall_cnt, BT + 1);

        // Reset while waiting for read data.
        memReadM = 1; memWriteM = 0; memSizeM = 2'b10; memUnsignedM = 0; aluOutM = 32'h300;
        exp_stall = 1; exp_req = 0;
        cycle();
        dmem_gnt = 1; dmem_rvalid = 0; exp_req = 1;
        cycle();
        dmem_gnt = 0; exp_req = 0;
        #2;
        rst = 0; memReadM = 0; model_rd = 0; exp_stall = 0;
        chk_bus = 1; chk_wr = 1; exp_addr = 0; exp_we = 0; exp_wdata = 0; exp_wstrb = 0;
        #1;
        chk("rst_req", 32'(dmem_req), 32'h0);
        chk("rst_rd", readDataM, 32'h0);
        cycle();
        rst = 1; chk_bus = 0;
        dmem_rvalid = 1; dmem_rdata = 32'hCAFEF00D;
        cycle();
        dmem_rvalid = 0;
        access(1, 0, 2'b10, 0, 32'h300, 0, 0, 1, 32'h0BADF00D);
        chk("post_rst_lw", readDataM, 32'h0BADF00D);

        for (int k = 0; k < 150; k++) begin
            logic rd, wr;
            wr = 1'($urandom_range(0, 2) == 0);
            rd = wr ? 1'($urandom_range(0, 3) == 0) : 1'b1;
            access(rd, wr, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom, $urandom,
                   $urandom_range(0, 4), $urandom_range(0, 4), $urandom);
            idle($urandom_range(0, 2));
        end

        chk_on = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
